// File: rtl/voter_pkg.sv
// voter_pkg: mode encodings, window-depth limits and count-width helper shared by the voter slice
package voter_pkg;
  localparam logic MODE_MAJ = 1'b0;
  localparam logic MODE_THR = 1'b1;
  localparam int WIN_MIN = 2;
  localparam int WIN_MAX = 64;
  function automatic int cw_f(input int win);
    return $clog2(win + 1);
  endfunction
endpackage

// File: rtl/sliding_window_voter_if.sv
// sliding_window_voter_if: sample/config inputs and vote outputs of the sliding-window voter
interface sliding_window_voter_if #(
  parameter int WIN = 3,
  parameter int CW = voter_pkg::cw_f(WIN)
);
  logic clear;
  logic in_valid;
  logic x;
  logic mode;
  logic [CW-1:0] thr;
  logic y;
  logic [CW-1:0] ones_cnt;
  logic window_full;
  logic out_valid;
  modport master(output clear, in_valid, x, mode, thr, input y, ones_cnt, window_full, out_valid);
  modport slave(input clear, in_valid, x, mode, thr, output y, ones_cnt, window_full, out_valid);
endinterface

// File: rtl/win_shift_reg.sv
// win_shift_reg: WIN-deep sample window, newest at bit 0, oldest tapped from the top bit
module win_shift_reg #(
  parameter int WIN = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           en,
  input  logic           d,
  output logic [WIN-1:0] win,
  output logic           old
);
  always_ff @(posedge clk or posedge rst)
    if (rst) win <= '0;
    else if (clear) win <= '0;
    else if (en) win <= {win[WIN-2:0], d};
  assign old = win[WIN-1];
endmodule

// File: rtl/sliding_window_voter.sv
// sliding_window_voter: running ones count over the last WIN accepted samples with a registered majority/threshold vote
module sliding_window_voter
  import voter_pkg::*;
#(
  parameter int WIN = 3,
  parameter bit TIE_ONE = 1'b0,
  localparam int CW = cw_f(WIN)
) (
  input logic clk,
  input logic rst,
  sliding_window_voter_if.slave bus
);
  if (WIN < WIN_MIN || WIN > WIN_MAX) begin : g_bad_win
    $error("sliding_window_voter: WIN out of range");
  end
  logic [WIN-1:0] win_bus;
  logic           old;
  logic           acc;
  logic [CW-1:0]  cnt_nxt;
  logic [CW:0]    dbl;
  logic           maj;
  logic           y_nxt;
  logic [CW-1:0]  fill;
  assign acc = bus.in_valid & ~bus.clear;
  win_shift_reg #(.WIN(WIN)) u_win (
    .clk(clk), .rst(rst), .clear(bus.clear), .en(acc), .d(bus.x), .win(win_bus), .old(old)
  );
  always_comb begin
    cnt_nxt = bus.ones_cnt + CW'(bus.x) - CW'(old);
    dbl = {cnt_nxt, 1'b0};
    maj = (dbl > (CW+1)'(WIN)) | ((dbl == (CW+1)'(WIN)) & TIE_ONE);
    y_nxt = (bus.mode == MODE_THR) ? (cnt_nxt >= bus.thr) : maj;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst || bus.clear) begin
      bus.ones_cnt <= '0;
      fill <= '0;
      bus.y <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (acc) begin
      bus.ones_cnt <= cnt_nxt;
      fill <= (fill == CW'(WIN)) ? fill : fill + 1'b1;
      bus.y <= y_nxt;
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  assign bus.window_full = (fill == CW'(WIN));
endmodule

// File: tb/tb_sliding_window_voter.sv
// tb_sliding_window_voter: directed vectors against several voter configurations sharing one stimulus stream
module tb_sliding_window_voter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic x = 1'b0;
  logic mode = 1'b0;
  logic [3:0] thr = '0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  sliding_window_voter_if #(.WIN(3)) i3();
  sliding_window_voter_if #(.WIN(4)) i4a();
  sliding_window_voter_if #(.WIN(4)) i4b();
  sliding_window_voter_if #(.WIN(8)) i8();
  sliding_window_voter_if #(.WIN(5)) i5();
  assign {i3.clear, i3.in_valid, i3.x, i3.mode, i3.thr} = {clear, in_valid, x, mode, thr[1:0]};
  assign {i4a.clear, i4a.in_valid, i4a.x, i4a.mode, i4a.thr} = {clear, in_valid, x, mode, thr[2:0]};
  assign {i4b.clear, i4b.in_valid, i4b.x, i4b.mode, i4b.thr} = {clear, in_valid, x, mode, thr[2:0]};
  assign {i8.clear, i8.in_valid, i8.x, i8.mode, i8.thr} = {clear, in_valid, x, mode, thr};
  assign {i5.clear, i5.in_valid, i5.x, i5.mode, i5.thr} = {clear, in_valid, x, mode, thr[2:0]};
  sliding_window_voter #(.WIN(3)) u3(.clk(clk), .rst(rst), .bus(i3));
  sliding_window_voter #(.WIN(4), .TIE_ONE(1'b0)) u4a(.clk(clk), .rst(rst), .bus(i4a));
  sliding_window_voter #(.WIN(4), .TIE_ONE(1'b1)) u4b(.clk(clk), .rst(rst), .bus(i4b));
  sliding_window_voter #(.WIN(8)) u8(.clk(clk), .rst(rst), .bus(i8));
  sliding_window_voter #(.WIN(5)) u5(.clk(clk), .rst(rst), .bus(i5));
  always @(negedge clk) begin
    assert (int'(i3.ones_cnt) == $countones(u3.win_bus)) else $error("FAIL popcount w3 got %0d", i3.ones_cnt);
    assert (int'(i4a.ones_cnt) == $countones(u4a.win_bus)) else $error("FAIL popcount w4a got %0d", i4a.ones_cnt);
    assert (int'(i4b.ones_cnt) == $countones(u4b.win_bus)) else $error("FAIL popcount w4b got %0d", i4b.ones_cnt);
    assert (int'(i8.ones_cnt) == $countones(u8.win_bus)) else $error("FAIL popcount w8 got %0d", i8.ones_cnt);
    assert (int'(i5.ones_cnt) == $countones(u5.win_bus)) else $error("FAIL popcount w5 got %0d", i5.ones_cnt);
  end
  typedef struct {
    logic v;
    logic xv;
    logic ey;
    int   ecnt;
    logic efull;
    logic eov;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic apply(input logic v, input logic xv);
    in_valid = v;
    x = xv;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int ov_cnt;
    tbl[0]  = '{1, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 1, 0, 1, 1, 1};
    tbl[3]  = '{1, 1, 1, 2, 1, 1};
    tbl[4]  = '{1, 1, 1, 3, 1, 1};
    tbl[5]  = '{1, 0, 1, 2, 1, 1};
    tbl[6]  = '{1, 1, 1, 2, 1, 1};
    tbl[7]  = '{1, 1, 1, 2, 1, 1};
    tbl[8]  = '{1, 0, 1, 2, 1, 1};
    tbl[9]  = '{1, 0, 0, 1, 1, 1};
    tbl[10] = '{1, 0, 0, 0, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 1, 1};
    tbl[12] = '{0, 1, 0, 0, 1, 0};
    tbl[13] = '{1, 1, 0, 1, 1, 1};
    #2;
    chk("reset_y", i3.y, 0);
    chk("reset_cnt", i3.ones_cnt, 0);
    chk("reset_full", i3.window_full, 0);
    chk("reset_ov", i3.out_valid, 0);
    do_reset();
    mode = 1'b0;
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].v, tbl[i].xv);
      chk($sformatf("maj3_y[%0d]", i), i3.y, tbl[i].ey);
      chk($sformatf("maj3_cnt[%0d]", i), i3.ones_cnt, tbl[i].ecnt);
      chk($sformatf("maj3_full[%0d]", i), i3.window_full, tbl[i].efull);
      chk($sformatf("maj3_ov[%0d]", i), i3.out_valid, tbl[i].eov);
    end
    do_reset();
    apply(1, 1); apply(1, 1); apply(1, 0); apply(1, 0);
    chk("tie_cnt", i4a.ones_cnt, 2);
    chk("tie0_y", i4a.y, 0);
    chk("tie1_y", i4b.y, 1);
    do_reset();
    mode = 1'b1;
    thr = 4'd5;
    for (int k = 1; k <= 8; k++) begin
      apply(1, 1);
      if (k == 4) chk("thr5_y_after4", i8.y, 0);
      if (k == 5) chk("thr5_y_after5", i8.y, 1);
    end
    chk("thr5_full", i8.window_full, 1);
    apply(1, 0); apply(1, 0); apply(1, 0);
    chk("thr5_cnt_3zeros", i8.ones_cnt, 5);
    chk("thr5_y_3zeros", i8.y, 1);
    apply(1, 0);
    chk("thr5_cnt_4zeros", i8.ones_cnt, 4);
    chk("thr5_y_4zeros", i8.y, 0);
    do_reset();
    thr = 4'd0;
    apply(1, 0);
    chk("thr0_y", i8.y, 1);
    do_reset();
    thr = 4'd9;
    for (int k = 0; k < 8; k++) apply(1, 1);
    chk("thr9_cnt", i8.ones_cnt, 8);
    chk("thr9_y", i8.y, 0);
    mode = 1'b0;
    apply(0, 1);
    chk("mode_change_idle_y", i8.y, 0);
    apply(1, 1);
    chk("mode_change_acc_y", i8.y, 1);
    chk("x_eq_old_cnt", i8.ones_cnt, 8);
    chk("x_eq_old_ov", i8.out_valid, 1);
    do_reset();
    mode = 1'b0;
    ov_cnt = 0;
    foreach (tbl[i]) if (i < 6) begin
      apply(logic'(i == 0 || i == 3 || i == 5), 1);
      ov_cnt += int'(i3.out_valid);
      if (i == 2) chk("gap_hold_cnt", i3.ones_cnt, 1);
      if (i == 4) chk("gap_hold_y", i3.y, 1);
    end
    chk("gap_ov_pulses", ov_cnt, 3);
    chk("gap_cnt_end", i3.ones_cnt, 3);
    do_reset();
    for (int k = 0; k < 5; k++) apply(1, 1);
    chk("w5_cnt_full", i5.ones_cnt, 5);
    chk("w5_y_full", i5.y, 1);
    clear = 1'b1;
    apply(1, 1);
    clear = 1'b0;
    chk("clear_cnt", i5.ones_cnt, 0);
    chk("clear_y", i5.y, 0);
    chk("clear_full", i5.window_full, 0);
    chk("clear_ov", i5.out_valid, 0);
    for (int k = 0; k < 5; k++) apply(1, 1);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", i5.ones_cnt, 0);
    chk("async_rst_y", i5.y, 0);
    chk("async_rst_full", i5.window_full, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
